rv_mem_arbiter: RTL

- Shares one single-ported unified memory between the Fetch stage (instruction reads) and the Memory stage (loads/stores) of the 5-stage RV32I pipeline.
- Sequences each access through a request/grant/response handshake with variable memory latency.
- Returns read data to the owning stage and produces per-stage stall signals that combine with the load-use stall and branch flush logic.
- Data-side requests have priority, because they belong to the older instruction.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/rv_mem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, access owner
// and the default address/data widths of the RV32I core.
package rv_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/rv_mem_arbiter.sv
// Single-ported memory arbiter shared by Fetch (instruction reads) and the
// Memory stage (loads/stores). The data side wins ties because it belongs to
// the older instruction. One access is outstanding at a time; a fetch made
// stale by a taken branch is either abandoned before grant or its response
// is dropped (Discard). Stores are never cancelled.
module rv_mem_arbiter
    import rv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                IReq,
    input  logic [ADDR_W-1:0]   IAddr,
    input  logic                FlushF,
    output logic [DATA_W-1:0]   IRData,
    output logic                IDone,
    input  logic                DReq,
    input  logic                DWe,
    input  logic [ADDR_W-1:0]   DAddr,
    input  logic [DATA_W-1:0]   DWData,
    input  logic [DATA_W/8-1:0] DBE,
    output logic [DATA_W-1:0]   DRData,
    output logic                DDone,
    output logic                IStall,
    output logic                DStall,
    output logic                MemReq,
    output logic                MemWe,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic [DATA_W-1:0]   MemWData,
    output logic [DATA_W/8-1:0] MemBE,
    input  logic                MemGnt,
    input  logic                MemRValid,
    input  logic [DATA_W-1:0]   MemRData,
    output logic                ErrProto
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state, state_next;
    owner_e            owner, owner_next;
    logic              discard, discard_next;
    logic              latch_d, latch_i, capture;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic [DATA_W-1:0] ir_data;
    logic [DATA_W-1:0] dr_data;
    logic              err_proto;

    // Control state: FSM, owner of the current access and stale-fetch marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owner   <= OWN_D;
            discard <= 1'b0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            discard <= discard_next;
        end
    end

    // Next-state logic: arbitration in IDLE, grant wait, response wait, done pulse.
    always_comb begin
        state_next   = state;
        owner_next   = owner;
        discard_next = discard;
        latch_d      = 1'b0;
        latch_i      = 1'b0;
        capture      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (DReq) begin
                    latch_d    = 1'b1;
                    owner_next = OWN_D;
                    state_next = ST_ISSUE;
                end else if (IReq && !FlushF) begin
                    latch_i    = 1'b1;
                    owner_next = OWN_I;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (owner == OWN_I && FlushF) begin
                    // Already accepted by memory: let it finish but drop the data.
                    if (MemGnt) begin
                        state_next   = ST_WAIT;
                        discard_next = 1'b1;
                    end else begin
                        state_next   = ST_IDLE;
                    end
                end else if (MemGnt) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (owner == OWN_I && FlushF) begin
                    discard_next = 1'b1;
                end
                if (MemRValid) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // The requester still holds its old request here, so no new sampling.
                discard_next = 1'b0;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch and read-data registers; memory sees only latched fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            ir_data   <= '0;
            dr_data   <= '0;
        end else begin
            if (latch_d) begin
                lat_we    <= DWe;
                lat_addr  <= DAddr;
                lat_wdata <= DWData;
                lat_be    <= DWe ? DBE : '1;
            end else if (latch_i) begin
                lat_we    <= 1'b0;
                lat_addr  <= IAddr;
                lat_wdata <= '0;
                lat_be    <= '1;
            end
            if (capture) begin
                if (owner == OWN_I) begin
                    ir_data <= MemRData;
                end else if (!lat_we) begin
                    dr_data <= MemRData;
                end
            end
        end
    end

    // Sticky protocol error: a response with no access outstanding in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_proto <= 1'b0;
        end else if (MemRValid && state != ST_WAIT) begin
            err_proto <= 1'b1;
        end
    end

    assign MemReq   = (state == ST_ISSUE);
    assign MemWe    = MemReq & lat_we;
    assign MemAddr  = lat_addr;
    assign MemWData = lat_wdata;
    assign MemBE    = lat_be;

    assign IDone    = (state == ST_RESP) && (owner == OWN_I) && !discard && !FlushF;
    assign DDone    = (state == ST_RESP) && (owner == OWN_D);
    assign IRData   = ir_data;
    assign DRData   = dr_data;
    assign IStall   = IReq & ~IDone;
    assign DStall   = DReq & ~DDone;
    assign ErrProto = err_proto;

endmodule
